oam_dma_arbiter: RTL

//  Owns the shared CPU memory bus and arbitrates it between the cpu core and the sprite (OAM) DMA engine.
//  A CPU write to DMA_REG_ADDR stalls the core via cpu_rdy.
//  It then copies XFER_LEN bytes from page {page,00}..{page,FF} to OAMDATA_ADDR.
//  Bus ownership then returns to the CPU.

---
 rtl/oam_dma_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: CPU/OAM-DMA bus arbiter; optional read alignment via OAM_DMA_ALIGN_EN
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter int XFER_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic        cpu_rdy,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  output logic        dma_busy,
  output logic        dma_done
);
`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  logic parity;
`else
  typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;
`endif
  localparam logic [8:0] LAST = 9'(XFER_LEN - 1);
  state_t state;
  logic [8:0] idx;
  logic [7:0] page, data_q;
  logic trig;
  assign trig = cpu_write && cpu_addr == DMA_REG_ADDR;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      page <= '0;
      data_q <= '0;
      dma_done <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      parity <= 1'b0;
`endif
    end else begin
      dma_done <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      parity <= ~parity;
`endif
      case (state)
        IDLE: if (trig) begin
          page <= cpu_d_out;
          state <= HALT;
        end
`ifdef OAM_DMA_ALIGN_EN
        HALT: state <= parity ? ALIGN : READ;
        ALIGN: state <= READ;
`else
        HALT: state <= READ;
`endif
        READ: begin
          data_q <= bus_d_in;
          state <= WRITE;
        end
        WRITE: if (idx == LAST) begin
          idx <= '0;
          dma_done <= 1'b1;
          state <= IDLE;
        end else begin
          idx <= idx + 9'd1;
          state <= READ;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    cpu_rdy = state == IDLE;
    dma_busy = state != IDLE;
    bus_addr = state == READ ? {page, idx[7:0]} : state == WRITE ? OAMDATA_ADDR : cpu_addr;
    bus_d_out = state == WRITE ? data_q : cpu_d_out;
    bus_write = state == WRITE || (state == IDLE && cpu_write);
  end
endmodule
